// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core
// load/store path and a debug/loader port. Core has priority; at most one
// grant per cycle, read data routed back to the granted port one cycle later.
// Optional debug starvation guard: define DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  // {dbg, core} read granted last cycle
  logic [1:0] rd_pend;
  logic       force_dbg;

`ifdef DMEM_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;

  assign force_dbg = (starve_cnt == CW'(STARVE_MAX)) && core_req && dbg_req;

  // Count consecutive debug losses to the core; saturates at STARVE_MAX
  always_ff @(posedge clk) begin
    if (reset)                                  starve_cnt <= '0;
    else if (dbg_gnt || !dbg_req)               starve_cnt <= '0;
    else if (core_gnt && starve_cnt != CW'(STARVE_MAX))
                                                starve_cnt <= starve_cnt + 1'b1;
  end
`else
  // Strict core priority; STARVE_MAX has no effect in this build
  assign force_dbg = (STARVE_MAX < 0);
`endif

  // Debug wins only when the core is idle or the guard forces it
  assign dbg_gnt  = !reset && dbg_req && (!core_req || force_dbg);
  assign core_gnt = !reset && core_req && !dbg_gnt;

  // Drive the memory command from the winner, zeros when idle
  always_comb begin
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (core_gnt) begin
      mem_wr      = core_we;
      mem_rd      = !core_we;
      mem_addr    = core_addr;
      mem_wr_data = core_wdata;
    end else if (dbg_gnt) begin
      mem_wr      = dbg_we;
      mem_rd      = !dbg_we;
      mem_addr    = dbg_addr;
      mem_wr_data = dbg_wdata;
    end
  end

  // Remember which port owns next cycle's read data
  always_ff @(posedge clk) begin
    if (reset) rd_pend <= 2'b00;
    else       rd_pend <= {dbg_gnt && !dbg_we, core_gnt && !core_we};
  end

  // Reset in the response cycle drops the pending read
  assign core_rvalid = rd_pend[0] && !reset;
  assign dbg_rvalid  = rd_pend[1] && !reset;
  assign core_rdata  = core_rvalid ? mem_rd_data : '0;
  assign dbg_rdata   = dbg_rvalid  ? mem_rd_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed test-plan steps plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_dmem_arbiter;
  localparam int DATA_W = 32, ADDR_W = 9, SMAX = 8;

  logic clk = 1'b0, reset = 1'b1;
  logic core_req = 0, core_we = 0, dbg_req = 0, dbg_we = 0;
  logic [ADDR_W-1:0] core_addr = '0, dbg_addr = '0;
  logic [DATA_W-1:0] core_wdata = '0, dbg_wdata = '0;
  logic core_gnt, core_rvalid, dbg_gnt, dbg_rvalid, mem_wr, mem_rd;
  logic [DATA_W-1:0] core_rdata, dbg_rdata, mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic [ADDR_W-1:0] mem_addr;

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data));

  always #5 clk = ~clk;

  // Synchronous single-port RAM attached to the memory side
  logic [DATA_W-1:0] ram [512];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_wr_data;
    if (mem_rd) mem_rd_data <= ram[mem_addr];
  end

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the memory this cycle, what comes back next
  logic [DATA_W-1:0] shadow [512];
  bit   pend_core = 0, pend_dbg = 0;
  logic [DATA_W-1:0] pend_data = '0;
  int   losses = 0;
  bit   e_cg, e_dg;
  bit   o_cg, o_dg, o_cv, o_dv;
  logic [DATA_W-1:0] o_crd, o_drd;

  task automatic tick();
    bit starve_on, force_d;
    logic [DATA_W-1:0] ex_addr, ex_wd;
    @(negedge clk);
`ifdef DMEM_ARB_STARVE_EN
    starve_on = 1;
`else
    starve_on = 0;
`endif
    force_d = starve_on && losses >= SMAX && core_req && dbg_req;
    e_dg = !reset && dbg_req && (!core_req || force_d);
    e_cg = !reset && core_req && !e_dg;
    ex_addr = e_cg ? DATA_W'(core_addr)  : e_dg ? DATA_W'(dbg_addr)  : '0;
    ex_wd   = e_cg ? core_wdata : e_dg ? dbg_wdata : '0;
    chk("core_gnt", DATA_W'(core_gnt), DATA_W'(e_cg));
    chk("dbg_gnt",  DATA_W'(dbg_gnt),  DATA_W'(e_dg));
    chk("mem_wr", DATA_W'(mem_wr), DATA_W'((e_cg && core_we) || (e_dg && dbg_we)));
    chk("mem_rd", DATA_W'(mem_rd), DATA_W'((e_cg && !core_we) || (e_dg && !dbg_we)));
    chk("mem_addr", DATA_W'(mem_addr), ex_addr);
    chk("mem_wr_data", mem_wr_data, (mem_wr === 1'b1 || (e_cg && core_we) || (e_dg && dbg_we)) ? ex_wd : ex_wd);
    chk("core_rvalid", DATA_W'(core_rvalid), DATA_W'(pend_core && !reset));
    chk("dbg_rvalid",  DATA_W'(dbg_rvalid),  DATA_W'(pend_dbg && !reset));
    chk("core_rdata", core_rdata, (pend_core && !reset) ? pend_data : '0);
    chk("dbg_rdata",  dbg_rdata,  (pend_dbg && !reset) ? pend_data : '0);
    o_cg = core_gnt; o_dg = dbg_gnt; o_cv = core_rvalid; o_dv = dbg_rvalid;
    o_crd = core_rdata; o_drd = dbg_rdata;
    @(posedge clk);
    if (reset) begin
      pend_core = 0; pend_dbg = 0; losses = 0;
    end else begin
      pend_core = e_cg && !core_we;
      pend_dbg  = e_dg && !dbg_we;
      if (pend_core || pend_dbg) pend_data = shadow[ex_addr[ADDR_W-1:0]];
      if ((e_cg && core_we) || (e_dg && dbg_we)) shadow[ex_addr[ADDR_W-1:0]] = ex_wd;
      if (e_dg || !dbg_req)  losses = 0;
      else if (e_cg)         losses = (losses < SMAX) ? losses + 1 : SMAX;
    end
    #1;
  endtask

  task automatic set_core(input bit req, input bit we, input int addr, input logic [DATA_W-1:0] wd);
    core_req = req; core_we = we; core_addr = ADDR_W'(addr); core_wdata = wd;
  endtask
  task automatic set_dbg(input bit req, input bit we, input int addr, input logic [DATA_W-1:0] wd);
    dbg_req = req; dbg_we = we; dbg_addr = ADDR_W'(addr); dbg_wdata = wd;
  endtask

  initial begin
    int first_dbg;
    for (int i = 0; i < 512; i++) begin ram[i] = '0; shadow[i] = '0; end

    // Reset held with both ports requesting: everything quiet
    set_core(1, 0, 3, '0); set_dbg(1, 0, 4, '0); reset = 1;
    @(posedge clk); #1;
    tick(); tick();
    chk("rst_core_gnt", DATA_W'(o_cg), 0);
    chk("rst_dbg_gnt",  DATA_W'(o_dg), 0);
    reset = 0;
    tick();
    chk("rel_core_gnt", DATA_W'(o_cg), 1);
    set_core(0, 0, 0, '0); set_dbg(0, 0, 0, '0);
    tick();

    // Core write then read back
    set_core(1, 1, 'h1A, 32'hDEADBEEF); tick();
    chk("cw_gnt", DATA_W'(o_cg), 1);
    set_core(1, 0, 'h1A, '0); tick();
    chk("cr_gnt", DATA_W'(o_cg), 1);
    set_core(0, 0, 0, '0); tick();
    chk("cr_rvalid", DATA_W'(o_cv), 1);
    chk("cr_rdata", o_crd, 32'hDEADBEEF);
    chk("cr_dbg_rvalid", DATA_W'(o_dv), 0);

    // Contention: both ports read continuously
    set_core(1, 0, 'h05, '0); set_dbg(1, 0, 'h06, '0);
    first_dbg = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (o_dg && first_dbg == 0) first_dbg = i;
    end
`ifdef DMEM_ARB_STARVE_EN
    chk("starve_first_dbg", DATA_W'(first_dbg), 9);
`else
    chk("strict_no_dbg", DATA_W'(first_dbg), 0);
`endif
    set_core(0, 0, 0, '0); tick();
    chk("dbg_after_core_drop", DATA_W'(o_dg), 1);
    set_dbg(0, 0, 0, '0); tick();

    // Interleaved reads with preloaded data
    set_core(1, 1, 'h10, 32'h11); tick();
    set_core(0, 0, 0, '0); set_dbg(1, 1, 'h20, 32'h22); tick();
    set_dbg(0, 0, 0, '0); set_core(1, 0, 'h10, '0); tick();
    set_core(0, 0, 0, '0); set_dbg(1, 0, 'h20, '0); tick();
    chk("il_core_rvalid", DATA_W'(o_cv), 1);
    chk("il_core_rdata", o_crd, 32'h11);
    chk("il_dbg_rvalid0", DATA_W'(o_dv), 0);
    set_dbg(0, 0, 0, '0); tick();
    chk("il_dbg_rvalid", DATA_W'(o_dv), 1);
    chk("il_dbg_rdata", o_drd, 32'h22);
    chk("il_core_rvalid0", DATA_W'(o_cv), 0);

    // Cross-port ordering at the top address
    set_dbg(1, 1, 'h1FF, 32'h0000CAFE); tick();
    set_dbg(0, 0, 0, '0); set_core(1, 0, 'h1FF, '0); tick();
    set_core(0, 0, 0, '0); tick();
    chk("xport_rdata", o_crd, 32'h0000CAFE);

    // Reset in the response cycle drops the read
    set_core(1, 0, 'h1FF, '0); tick();
    set_core(0, 0, 0, '0); reset = 1; tick();
    chk("midrst_rvalid", DATA_W'(o_cv), 0);
    reset = 0; tick(); tick();
    chk("postrst_rvalid", DATA_W'(o_cv), 0);

    // Random traffic on a small address window to exercise read-after-write
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      set_core($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
      set_dbg($urandom_range(0, 4) != 0, $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
      tick();
      assert (!(o_cg && o_dg)) else begin
        errors++;
        $error("FAIL dual_gnt observed=%b%b expected=not both", o_cg, o_dg);
      end
      checks++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
